// File: rtl/spi_master_link.sv
// spi_master_link: SPI mode-0, MSB-first initiator for the DSO command protocol (control byte + payload).
// Define SPI_MASTER_ID_CHECK_EN to add id_err and skip the payload when the device ID is unexpected.
module spi_master_link #(
    parameter int unsigned HALF_DIV  = 4,
    parameter int unsigned LEN_W     = 14,
    parameter int unsigned CS_GAP    = 8
`ifdef SPI_MASTER_ID_CHECK_EN
    ,
    parameter logic [7:0]  EXPECT_ID = 8'h91
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [7:0]       id_byte,
    output logic             busy,
    output logic             done,
    output logic             ncs_spi,
    output logic             sck_spi,
    output logic             mosi_spi,
    input  logic             miso_spi
`ifdef SPI_MASTER_ID_CHECK_EN
    ,
    output logic             id_err
`endif
);

    localparam int unsigned CntMax = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_DIV - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLow,
        StHigh,
        StFetch,
        StHold,
        StGap
    } state_e;

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift_tx;   // bits still to send after the one already on mosi
    logic [7:0]       shift_rx;
    logic [LEN_W-1:0] bytes_left;
    logic             in_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_tx   <= '0;
            shift_rx   <= '0;
            bytes_left <= '0;
            in_ctrl    <= 1'b0;
            tx_ready   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            id_byte    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ncs_spi    <= 1'b1;
            sck_spi    <= 1'b0;
            mosi_spi   <= 1'b0;
`ifdef SPI_MASTER_ID_CHECK_EN
            id_err     <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy       <= 1'b1;
                        ncs_spi    <= 1'b0;
                        mosi_spi   <= cmd[7];
                        shift_tx   <= cmd[6:0];
                        bytes_left <= len;
                        in_ctrl    <= 1'b1;
                        cnt        <= '0;
                        bit_cnt    <= '0;
`ifdef SPI_MASTER_ID_CHECK_EN
                        id_err     <= 1'b0;
`endif
                        state      <= StSetup;
                    end
                end
                // miso is sampled on the same clk edge that raises sck
                StSetup, StLow: begin
                    if (cnt == HalfLast) begin
                        cnt      <= '0;
                        sck_spi  <= 1'b1;
                        shift_rx <= {shift_rx[6:0], miso_spi};
                        state    <= StHigh;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StHigh: begin
                    if (cnt == HalfLast) begin
                        cnt     <= '0;
                        sck_spi <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (in_ctrl) begin
                                in_ctrl <= 1'b0;
                                id_byte <= shift_rx;
`ifdef SPI_MASTER_ID_CHECK_EN
                                if (shift_rx != EXPECT_ID) begin
                                    id_err <= 1'b1;
                                    state  <= StHold;
                                end else
`endif
                                if (bytes_left == '0) begin
                                    state <= StHold;
                                end else begin
                                    state <= StFetch;
                                end
                            end else begin
                                rx_data    <= shift_rx;
                                rx_valid   <= 1'b1;
                                bytes_left <= bytes_left - LEN_W'(1);
                                state      <= (bytes_left == LEN_W'(1)) ? StHold : StFetch;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            mosi_spi <= shift_tx[6];
                            shift_tx <= {shift_tx[5:0], 1'b0};
                            state    <= StLow;
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                // sck is stretched low here until the producer has a byte ready
                StFetch: begin
                    if (tx_valid) begin
                        tx_ready <= 1'b1;
                        mosi_spi <= tx_data[7];
                        shift_tx <= tx_data[6:0];
                        cnt      <= '0;
                        state    <= StLow;
                    end
                end
                StHold: begin
                    if (cnt == HalfLast) begin
                        cnt     <= '0;
                        ncs_spi <= 1'b1;
                        done    <= 1'b1;
                        state   <= StGap;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt == GapLast) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_link.sv
// tb_spi_master_link: randomized scoreboard bench for spi_master_link with a behavioural SPI peripheral.
// Builds with or without SPI_MASTER_ID_CHECK_EN.
module tb_spi_master_link;
    localparam int HALF_DIV = 4;
    localparam int LEN_W    = 14;
    localparam int CS_GAP   = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic [7:0]       cmd      = 8'h00;
    logic [LEN_W-1:0] len      = '0;
    logic [7:0]       tx_data  = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       id_byte;
    logic             busy;
    logic             done;
    logic             ncs_spi;
    logic             sck_spi;
    logic             mosi_spi;
    logic             miso_spi = 1'b0;
`ifdef SPI_MASTER_ID_CHECK_EN
    logic             id_err;
`endif

    spi_master_link #(
        .HALF_DIV (HALF_DIV),
        .LEN_W    (LEN_W),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .len      (len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .id_byte  (id_byte),
        .busy     (busy),
        .done     (done),
        .ncs_spi  (ncs_spi),
        .sck_spi  (sck_spi),
        .mosi_spi (mosi_spi),
        .miso_spi (miso_spi)
`ifdef SPI_MASTER_ID_CHECK_EN
        ,
        .id_err   (id_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expected payload bytes, tallies pulses and sck edges.
    logic [7:0] exp_rx_q[$];
    int rx_cnt = 0, txr_cnt = 0, done_cnt = 0, multi_done = 0, rise_cnt = 0, phase_err = 0;
    int done_cyc = 0, last_fall_cyc = 0, run = 0;
    logic mon_sck_prev = 1'b0, mon_done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_sck_prev  = 1'b0;
            mon_done_prev = 1'b0;
            run           = 0;
        end else begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %02h, no byte expected", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx_q.pop_front());
                end
            end
            if (tx_ready) txr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (mon_done_prev) multi_done++;
            end
            mon_done_prev = done;
            if (sck_spi == mon_sck_prev) begin
                run++;
            end else begin
                if (mon_sck_prev) begin
                    if (run != HALF_DIV) phase_err++;
                    last_fall_cyc = cyc;
                end else begin
                    rise_cnt++;
                    if (run < HALF_DIV) phase_err++;
                end
                run = 1;
            end
            mon_sck_prev = sck_spi;
        end
    end

    // Peripheral model: returns slv_id then one queued byte per payload byte; logs mosi bytes.
    logic [7:0] slv_id = 8'h91;
    logic [7:0] slv_q[$];
    logic [7:0] mosi_log[$];
    logic [7:0] s_sr = 8'h00, m_acc = 8'h00;
    int s_bits = 0, m_bits = 0;
    logic s_ncs_prev = 1'b1, s_sck_prev = 1'b0;
    always @(negedge clk) begin
        if (!ncs_spi && s_ncs_prev) begin
            s_sr     = slv_id;
            s_bits   = 0;
            m_bits   = 0;
            miso_spi = s_sr[7];
        end else if (!ncs_spi) begin
            if (sck_spi && !s_sck_prev) begin
                m_acc = {m_acc[6:0], mosi_spi};
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    mosi_log.push_back(m_acc);
                end
            end
            if (!sck_spi && s_sck_prev) begin
                s_sr = {s_sr[6:0], 1'b0};
                s_bits++;
                if (s_bits == 8) begin
                    s_bits = 0;
                    s_sr   = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
                end
                miso_spi = s_sr[7];
            end
        end
        s_ncs_prev = ncs_spi;
        s_sck_prev = sck_spi;
    end

    // Payload producer with an optional stall before byte index stall_at.
    logic [7:0] tx_q[$];
    int tx_idx = 0, pay_done = 0, stall_cnt = 0;
    int stall_at = -1, stall_len = 0, stall_sck = 0, stall_hits = 0;
    always @(negedge clk) begin
        bit hold_off;
        if (!busy) begin
            tx_idx    = 0;
            pay_done  = 0;
            stall_cnt = 0;
        end else begin
            if (tx_ready) begin
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                tx_idx++;
            end
            if (rx_valid) pay_done++;
        end
        hold_off = (tx_idx == stall_at) && (stall_cnt < stall_len);
        if (tx_q.size() > 0 && !hold_off) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
        if (hold_off && busy && pay_done >= stall_at) begin
            stall_cnt++;
            if (sck_spi) stall_sck++;
            if (stall_cnt == stall_len) stall_hits++;
        end
    end

    logic [7:0] tx_buf[$];
    logic [7:0] rsp_buf[$];

    task automatic fill_rand(input int n);
        tx_buf.delete();
        rsp_buf.delete();
        for (int i = 0; i < n; i++) begin
            tx_buf.push_back(8'($urandom));
            rsp_buf.push_back(8'($urandom));
        end
    endtask

    task automatic run_txn(input string tag, input logic [7:0] c, input int n,
                           input logic [7:0] idv, input int s_at, input int s_len, input bit poke);
        int eff, k, gap;
        int r0, d0, t0, x0, m0, pe0, ss0, sh0, md0;
        logic [7:0] exp_m[$];
        bit id_bad;
        eff    = n;
        id_bad = 1'b0;
`ifdef SPI_MASTER_ID_CHECK_EN
        if (idv != 8'h91) begin
            eff    = 0;
            id_bad = 1'b1;
        end
`endif
        r0 = rise_cnt; d0 = done_cnt; t0 = txr_cnt; x0 = rx_cnt; m0 = mosi_log.size();
        pe0 = phase_err; ss0 = stall_sck; sh0 = stall_hits; md0 = multi_done;
        slv_id = idv;
        exp_m.push_back(c);
        for (int i = 0; i < n; i++) tx_q.push_back(tx_buf[i]);
        for (int i = 0; i < eff; i++) begin
            exp_m.push_back(tx_buf[i]);
            slv_q.push_back(rsp_buf[i]);
            exp_rx_q.push_back(rsp_buf[i]);
        end
        stall_at  = s_at;
        stall_len = s_len;
        @(negedge clk);
        cmd   = c;
        len   = LEN_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmd   = 8'($urandom);
        len   = LEN_W'($urandom_range(0, 9));
        if (poke) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (done_cnt == d0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: no done after %0d cycles, expected one", tag, k);
        end
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        gap = cyc - done_cyc;
        check({tag, "_gap_ge_cs_gap"}, 64'(gap >= CS_GAP), 64'd1);
        check({tag, "_sck_rises"}, rise_cnt - r0, 8 * (1 + eff));
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_done_width"}, multi_done - md0, 0);
        check({tag, "_done_after_fall"}, done_cyc - last_fall_cyc, HALF_DIV);
        check({tag, "_sck_phase"}, phase_err - pe0, 0);
        check({tag, "_id_byte"}, id_byte, idv);
        check({tag, "_tx_ready_cnt"}, txr_cnt - t0, eff);
        check({tag, "_rx_valid_cnt"}, rx_cnt - x0, eff);
        check({tag, "_rx_pending"}, exp_rx_q.size(), 0);
        check({tag, "_mosi_bytes"}, mosi_log.size() - m0, exp_m.size());
        for (int i = 0; i < exp_m.size(); i++) begin
            if (m0 + i < mosi_log.size()) check({tag, "_mosi"}, mosi_log[m0 + i], exp_m[i]);
        end
        if (s_at >= 0) begin
            check({tag, "_stall_sck_high"}, stall_sck - ss0, 0);
            check({tag, "_stall_seen"}, stall_hits - sh0, 1);
        end
`ifdef SPI_MASTER_ID_CHECK_EN
        check({tag, "_id_err"}, id_err, id_bad);
`endif
        tx_q.delete();
        exp_rx_q.delete();
        stall_at = -1;
    endtask

    task automatic reset_mid();
        int k, r0, d0;
        fill_rand(3);
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(tx_buf[i]);
            slv_q.push_back(rsp_buf[i]);
        end
        slv_id   = 8'h91;
        stall_at = -1;
        r0 = rise_cnt;
        d0 = done_cnt;
        @(negedge clk);
        cmd   = 8'h82;
        len   = LEN_W'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (rise_cnt - r0 < 11 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reached_bit3", rise_cnt - r0, 11);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ncs_sck_busy", {ncs_spi, sck_spi, busy}, 3'b100);
        rst = 1'b0;
        tx_q.delete();
        slv_q.delete();
        repeat (40) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs",
              {ncs_spi, sck_spi, mosi_spi, busy, done, tx_ready, rx_valid, rx_data, id_byte},
              {1'b1, 6'b000000, 8'h00, 8'h00});
`ifdef SPI_MASTER_ID_CHECK_EN
        check("reset_id_err", id_err, 1'b0);
`endif

        fill_rand(4);
        tx_buf = {8'h12, 8'h34, 8'h56, 8'h78};
        run_txn("adc_write", 8'h80, 4, 8'h91, -1, 0, 1'b0);

        tx_buf  = {8'h00, 8'h00, 8'h00, 8'h00};
        rsp_buf = {8'h12, 8'h34, 8'hA5, 8'h5A};
        run_txn("status_read", 8'h01, 4, 8'h91, -1, 0, 1'b0);

        fill_rand(3);
        run_txn("stall", 8'h85, 3, 8'h91, 2, 50, 1'b0);

        fill_rand(0);
        run_txn("ctrl_only", 8'h03, 0, 8'h91, -1, 0, 1'b0);

        reset_mid();
        fill_rand(2);
        run_txn("after_reset", 8'h84, 2, 8'h91, -1, 0, 1'b0);

        fill_rand(2);
        run_txn("bad_id", 8'h81, 2, 8'h00, -1, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int n, s_at;
            n    = $urandom_range(0, 5);
            s_at = (n >= 2) ? $urandom_range(1, n - 1) : -1;
            fill_rand(n);
            run_txn("random", 8'($urandom), n, 8'h91, s_at, $urandom_range(1, 20), t == 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
